// File: rtl/mac_ifmaps_multirow_fifo_pkg.sv
// Shared defaults and helpers for the MAC ifmaps row buffer.
package mac_ifmaps_multirow_fifo_pkg;

  localparam int DEF_DATA_WIDTH     = 1;
  localparam int DEF_NUM_ROWS       = 5;
  localparam int DEF_DEPTH          = 8;
  localparam int DEF_ALMOST_FULL_TH = 6;

  // Occupancy update selected by the accepted write/read pair of a cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A simultaneous write and read leaves the occupancy unchanged.
  function automatic cnt_op_e cnt_op(input logic wr_ok, input logic rd_ok);
    cnt_op_e op;
    op = CNT_HOLD;
    if (wr_ok && !rd_ok) op = CNT_INC;
    if (rd_ok && !wr_ok) op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/mac_ifmaps_multirow_fifo_mem.sv
// Storage array for the ifmaps row buffer: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module mac_ifmaps_multirow_fifo_mem #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: store one column slice per accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Read port: sample the pre-edge entry, so a same-address write lands after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_rdata <= '0;
    else if (rd_en) r_rdata <= r_mem[rd_addr];
  end

  assign rd_data = r_rdata;

endmodule

// File: rtl/mac_ifmaps_multirow_fifo.sv
// Ifmaps row buffer in front of the binary MAC array: pointers, occupancy,
// accept logic, status flags and sticky error bits around the storage array.
module mac_ifmaps_multirow_fifo
  import mac_ifmaps_multirow_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_ROWS       = DEF_NUM_ROWS,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ALMOST_FULL_TH = DEF_ALMOST_FULL_TH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_ROWS*DATA_WIDTH-1:0] ifmaps_in,
  input  logic                           ifmaps_input_valid,
  input  logic                           fifo_read,
  input  logic                           fifo_flush,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] ifmaps_out,
  output logic                           ifmaps_out_valid,
  output logic                           fifo_full,
  output logic                           fifo_empty,
  output logic                           fifo_almost_full,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic                           overflow_err,
  output logic                           underflow_err
);

  localparam int W  = NUM_ROWS * DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_vld;
  logic          r_ovf;
  logic          r_unf;

  logic          w_full;
  logic          w_empty;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic          w_mem_wr;
  logic          w_mem_rd;
  cnt_op_e       w_cnt_op;

  // Flags come straight from the registered occupancy.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full buffer still takes a write when a read frees a slot in the same cycle;
  // an empty buffer never forwards a same-cycle write to the reader.
  assign w_rd_ok  = fifo_read & ~w_empty;
  assign w_wr_ok  = ifmaps_input_valid & (~w_full | w_rd_ok);
  assign w_mem_wr = w_wr_ok & ~fifo_flush;
  assign w_mem_rd = w_rd_ok & ~fifo_flush;
  assign w_cnt_op = cnt_op(w_wr_ok, w_rd_ok);

  mac_ifmaps_multirow_fifo_mem #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_mem_wr),
    .wr_addr (r_wr_ptr),
    .wr_data (ifmaps_in),
    .rd_en   (w_mem_rd),
    .rd_addr (r_rd_ptr),
    .rd_data (ifmaps_out)
  );

  // Pointers and occupancy; flush wins over any accepted read or write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (fifo_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      case (w_cnt_op)
        CNT_INC: r_count <= r_count + CW'(1);
        CNT_DEC: r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle strobe marking that the read register took a new entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_vld <= 1'b0;
    else        r_out_vld <= w_mem_rd;
  end

  // Sticky errors for refused requests; cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (fifo_flush) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (ifmaps_input_valid && !w_wr_ok) r_ovf <= 1'b1;
      if (fifo_read && !w_rd_ok)          r_unf <= 1'b1;
    end
  end

  assign ifmaps_out_valid = r_out_vld;
  assign fifo_full        = w_full;
  assign fifo_empty       = w_empty;
  assign fifo_almost_full = (r_count >= CW'(ALMOST_FULL_TH));
  assign fifo_count       = r_count;
  assign overflow_err     = r_ovf;
  assign underflow_err    = r_unf;

endmodule

// File: tb/tb_mac_ifmaps_multirow_fifo.sv
// Self-checking bench for the ifmaps row buffer (5 rows x 1 bit, depth 8, almost-full at 6).
module tb_mac_ifmaps_multirow_fifo;

  localparam int DW    = 1;
  localparam int NR    = 5;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int W     = NR * DW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  din = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          fl = 1'b0;
  logic [W-1:0]  dout;
  logic          vld;
  logic          full;
  logic          empty;
  logic          afull;
  logic [CW-1:0] count;
  logic          ovf;
  logic          unf;

  mac_ifmaps_multirow_fifo #(
    .DATA_WIDTH     (DW),
    .NUM_ROWS       (NR),
    .DEPTH          (DEPTH),
    .ALMOST_FULL_TH (AFT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ifmaps_in          (din),
    .ifmaps_input_valid (wr),
    .fifo_read          (rd),
    .fifo_flush         (fl),
    .ifmaps_out         (dout),
    .ifmaps_out_valid   (vld),
    .fifo_full          (full),
    .fifo_empty         (empty),
    .fifo_almost_full   (afull),
    .fifo_count         (count),
    .overflow_err       (ovf),
    .underflow_err      (unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_out = '0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic         m_vld = 1'b0;

  typedef struct {
    logic         w;
    logic         r;
    logic [W-1:0] d;
    logic         ev;
    logic [W-1:0] ed;
    int           ec;
    logic         ee;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, " count"}, 32'(count), 32'(sz));
    chk({tag, " empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, " full"},  32'(full),  32'(sz == DEPTH));
    chk({tag, " afull"}, 32'(afull), 32'(sz >= AFT));
    chk({tag, " ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, " unf"},   32'(unf),   32'(m_unf));
  endtask

  // One clock with the given requests; called and returns at posedge+1.
  task automatic cycle(input string tag, input logic w, input logic r, input logic f,
                       input logic [W-1:0] d);
    bit rd_ok, wr_ok;
    wr = w; rd = r; fl = f; din = d;
    rd_ok = r && (mq.size() != 0);
    wr_ok = w && ((mq.size() != DEPTH) || rd_ok);
    m_vld = 1'b0;
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_unf = 1'b1;
      if (rd_ok) begin
        exp_q.push_back(mq.pop_front());
        m_vld = 1'b1;
      end
      if (wr_ok) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; fl = 1'b0;
    chk({tag, " valid"}, 32'(vld), 32'(m_vld));
    if (m_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s scoreboard: got %0h, expected no pending entry", tag, dout);
      end else begin
        m_out = exp_q.pop_front();
        chk({tag, " data"}, 32'(dout), 32'(m_out));
      end
    end else begin
      chk({tag, " hold"}, 32'(dout), 32'(m_out));
    end
    chk_status(tag);
  endtask

  initial begin
    logic [W-1:0] d;

    // Reset state
    #12;
    chk("rst valid", 32'(vld), 32'd0);
    chk("rst dout",  32'(dout), 32'd0);
    chk_status("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ordering vectors
    vecs[0] = '{1'b1, 1'b0, 5'b01010, 1'b0, 5'b00000, 1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 5'b11111, 1'b0, 5'b00000, 2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 5'b00101, 1'b0, 5'b00000, 3, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 5'b00000, 1'b1, 5'b01010, 2, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 5'b00000, 1'b1, 5'b11111, 1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 5'b00000, 1'b1, 5'b00101, 0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 5'b00000, 1'b0, 5'b00101, 0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      wr = vecs[i].w; rd = vecs[i].r; din = vecs[i].d;
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0;
      chk($sformatf("vec%0d valid", i), 32'(vld),   32'(vecs[i].ev));
      chk($sformatf("vec%0d dout", i),  32'(dout),  32'(vecs[i].ed));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].ee));
    end
    m_out = 5'b00101;

    // Fill to full, then overflow, then drain
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, 1'b0, W'(i + 3));
    cycle("overflow", 1'b1, 1'b0, 1'b0, 5'b11110);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 1'b0, '0);
    cycle("flush1", 1'b0, 1'b0, 1'b1, '0);

    // Full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 1'b0, 1'b0, W'(5'h10 + i));
    cycle("full rw", 1'b1, 1'b1, 1'b0, 5'b10101);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 1'b1, 1'b0, '0);

    // Empty with simultaneous read and write
    cycle("empty rw", 1'b1, 1'b1, 1'b0, 5'b01101);
    cycle("empty rd", 1'b0, 1'b1, 1'b0, '0);
    cycle("flush2", 1'b0, 1'b0, 1'b1, '0);

    // Pointer wrap at occupancy 3
    for (int i = 0; i < 3; i++) cycle("wrap pre", 1'b1, 1'b0, 1'b0, W'($urandom));
    for (int i = 0; i < 20; i++) begin
      cycle("wrap wr", 1'b1, 1'b0, 1'b0, W'($urandom));
      cycle("wrap rd", 1'b0, 1'b1, 1'b0, '0);
    end
    for (int i = 0; i < 3; i++) cycle("wrap post", 1'b0, 1'b1, 1'b0, '0);

    // Flush with entries queued, errors set and a read pending
    cycle("unf set", 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle("pre flush", 1'b1, 1'b0, 1'b0, W'(i + 9));
    cycle("flush rd", 1'b0, 1'b1, 1'b1, '0);
    cycle("post flush", 1'b1, 1'b0, 1'b0, 5'b00011);
    cycle("post flush rd", 1'b0, 1'b1, 1'b0, '0);

    // Asynchronous reset mid-burst
    cycle("unf set2", 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle("pre rst", 1'b1, 1'b0, 1'b0, W'(i + 20));
    wr = 1'b1; din = 5'b11001;
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
    chk("arst valid", 32'(vld), 32'd0);
    chk("arst dout", 32'(dout), 32'd0);
    chk_status("arst");
    wr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_status("arst held");
    d = 5'b10110;
    cycle("post rst wr", 1'b1, 1'b0, 1'b0, d);
    cycle("post rst rd", 1'b0, 1'b1, 1'b0, '0);
    cycle("idle", 1'b0, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
